data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i enables byte lane i (bits 8i+7:8i).
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load data.
REQ-014 SHALL have port rsp_err  output  1  access error flag.
REQ-015 SHALL have port busy  output  1  transaction in flight.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-017 SHALL drive req_ready = 1 only in IDLE; request accepted on edge where req_valid && req_ready.
REQ-018 SHALL capture req_we, req_addr, req_wdata, req_be at acceptance; later changes on request inputs ignored.
REQ-019 SHALL go IDLE -> WAIT on accept when WAIT_CYCLES > 0, else IDLE -> RESP directly.
REQ-020 SHALL stay in WAIT exactly WAIT_CYCLES cycles using a down-counter, then go to RESP.
REQ-021 SHALL perform the memory access on the edge entering RESP; rsp_valid first seen high WAIT_CYCLES+1 edges after acceptance edge.
REQ-022 SHALL flag error when addr[1:0] != 0 or addr >= DEPTH*4; error access: no write, rsp_rdata = 0, rsp_err = 1.
REQ-023 SHALL, on valid store, update only bytes with be bit set at word addr[log2(DEPTH)+1:2]; rsp_rdata = 0, rsp_err = 0.
REQ-024 SHALL treat store with be = 4'b0000 as legal no-op, rsp_err = 0.
REQ-025 SHALL, on valid load, return full 32-bit word (be ignored), rsp_err = 0.
REQ-026 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_valid && rsp_ready; then go IDLE, rsp_valid = 0.
REQ-027 SHALL NOT accept a new request in the cycle the response handshakes; earliest next accept is one cycle later (req_ready rises in IDLE).
REQ-028 SHALL return load data reflecting all previously completed stores (read-after-write ordering, one outstanding transaction).

Reset
REQ-029 SHALL on rst force state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0; req_ready = 1 after rst deasserts.
REQ-030 SHALL discard an in-flight transaction on reset; a store not yet reaching RESP SHALL NOT modify memory.
REQ-031 SHALL NOT reset memory contents.

Verification
REQ-032 Store 0x00000010 <- 0xDEADBEEF be=1111, WAIT_CYCLES=2 -> rsp_valid 3 edges after accept, rsp_err=0; load 0x10 -> rsp_rdata=0xDEADBEEF.
REQ-033 Store 0x10 <- 0x11223344 be=0101 over 0xDEADBEEF -> load returns 0xDE22BE44.
REQ-034 Load 0x00000012 -> rsp_err=1, rsp_rdata=0; load 0x1000 with DEPTH=1024 -> rsp_err=1; memory unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; handshake -> IDLE next cycle.
REQ-036 Assert rst during WAIT of store 0x20 <- 0xCAFEF00D -> outputs zero, busy=0; subsequent load 0x20 returns prior content.
REQ-037 WAIT_CYCLES=0, back-to-back requests with rsp_ready=1 -> one response per accept, one idle cycle between transactions.

Source files
------------

// File: rtl/data_mem_resp.sv
// Single-port word memory with a valid/ready request and response handshake.
// Each request waits a fixed number of cycles, then its response is held until the requester accepts it.
module data_mem_resp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;

  logic          cap_we;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_be;

  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic          enter_resp;

  logic [31:0]   mem [DEPTH];

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; WAIT counts down from WAIT_CYCLES-1 so it lasts exactly WAIT_CYCLES cycles.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = RESP;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live request then.
  assign acc_we    = accept ? req_we    : cap_we;
  assign acc_addr  = accept ? req_addr  : cap_addr;
  assign acc_wdata = accept ? req_wdata : cap_wdata;
  assign acc_be    = accept ? req_be    : cap_be;

  assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
  assign acc_idx    = acc_addr[AW+1:2];
  assign enter_resp = (next_state == RESP) && (state != RESP) && !rst;

  // Memory contents survive reset; only a transaction that reaches RESP may write.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // Request capture and registered handshake/response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_be    <= req_be;
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_we || acc_err) ? 32'h0 : mem[acc_idx];
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: a WAIT_CYCLES=2 instance for single transactions
// and a WAIT_CYCLES=0 instance for back-to-back traffic.
module tb_data_mem_resp;

  localparam int unsigned DEPTH_A = 1024;
  localparam int unsigned W_A     = 2;
  localparam int unsigned DEPTH_B = 64;
  localparam int unsigned W_B     = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int passed = 0;
  int total  = 0;
  logic [32:0] exp_q [$];
  logic [31:0] model_a [int unsigned];
  logic [31:0] model_b [int unsigned];

  data_mem_resp #(.DEPTH(DEPTH_A), .WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  data_mem_resp #(.DEPTH(DEPTH_B), .WAIT_CYCLES(W_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  // Reference model: returns {err, rdata} and applies legal stores to the model memory.
  function automatic logic [32:0] predict(input bit sel_b, input logic we, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] be);
    int unsigned depth;
    int unsigned idx;
    logic [31:0] word;
    depth = sel_b ? DEPTH_B : DEPTH_A;
    idx   = addr / 4;
    if (addr[1:0] != 2'b00 || addr >= depth * 4) return {1'b1, 32'h0};
    if (sel_b) word = model_b.exists(idx) ? model_b[idx] : 32'h0;
    else       word = model_a.exists(idx) ? model_a[idx] : 32'h0;
    if (!we) return {1'b0, word};
    for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
    if (sel_b) model_b[idx] = word;
    else       model_a[idx] = word;
    return {1'b0, 32'h0};
  endfunction

  // One transaction on instance A; inputs are scrambled after accept to prove capture.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, input string name);
    logic [32:0] exp;
    int lat;
    exp_q.push_back(predict(1'b0, we, addr, wdata, be));
    @(negedge clk);
    total++;
    if (a_req_ready !== 1'b1) $display("FAIL %s ready_before: got %b want 1", name, a_req_ready);
    else passed++;
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    a_rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0; a_req_we = ~we; a_req_addr = addr ^ 32'h4;
    a_req_wdata = ~wdata; a_req_be = ~be;
    lat = 1;
    while (a_rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != int'(W_A) + 1) $display("FAIL %s latency: got %0d edges want %0d", name, lat, W_A + 1);
    else passed++;
    exp = exp_q.pop_front();
    total++;
    if ({a_rsp_err, a_rsp_rdata} !== exp)
      $display("FAIL %s response: got err=%b data=%h want err=%b data=%h",
               name, a_rsp_err, a_rsp_rdata, exp[32], exp[31:0]);
    else passed++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (a_rsp_valid !== 1'b1 || {a_rsp_err, a_rsp_rdata} !== exp || a_req_ready !== 1'b0 || a_busy !== 1'b1)
        $display("FAIL %s hold%0d: got valid=%b err=%b data=%h ready=%b busy=%b want 1 %b %h 0 1",
                 name, i, a_rsp_valid, a_rsp_err, a_rsp_rdata, a_req_ready, a_busy, exp[32], exp[31:0]);
      else passed++;
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0)
      $display("FAIL %s after_handshake: got valid=%b ready=%b busy=%b want 0 1 0",
               name, a_rsp_valid, a_req_ready, a_busy);
    else passed++;
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0 || a_busy !== 1'b0)
      $display("FAIL reset_outputs: got valid=%b data=%h err=%b busy=%b want 0 0 0 0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || b_busy !== 1'b0)
      $display("FAIL reset_ready: got a_ready=%b b_ready=%b b_busy=%b want 1 1 0",
               a_req_ready, b_req_ready, b_busy);
    else passed++;
  endtask

  task automatic test_store_load();
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, "store_full");
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, "load_full");
    txn(1'b1, 32'hFFC, 32'h0BADF00D, 4'b1111, 0, "store_last");
    txn(1'b0, 32'hFFC, 32'h0, 4'b1010, 0, "load_last");
  endtask

  task automatic test_byte_enable();
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, "store_be0101");
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, "load_merged");
    total++;
    if (model_a[4] !== 32'hDE22BE44) $display("FAIL merge_model: got %h want DE22BE44", model_a[4]);
    else passed++;
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, "store_be0000");
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, "load_after_noop");
  endtask

  task automatic test_errors();
    txn(1'b0, 32'h12, 32'h0, 4'b0000, 0, "load_misaligned");
    txn(1'b0, 32'h1000, 32'h0, 4'b0000, 0, "load_oob");
    txn(1'b1, 32'h1010, 32'h55555555, 4'b1111, 0, "store_oob");
    txn(1'b1, 32'h11, 32'h66666666, 4'b1111, 0, "store_misaligned");
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 0, "load_unchanged");
  endtask

  task automatic test_backpressure();
    txn(1'b0, 32'h10, 32'h0, 4'b0000, 5, "load_held");
  endtask

  task automatic test_reset_inflight();
    txn(1'b1, 32'h20, 32'h01020304, 4'b1111, 0, "store_prior");
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h20;
    a_req_wdata = 32'hCAFEF00D; a_req_be = 4'b1111; a_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    total++;
    if (a_busy !== 1'b1 || a_rsp_valid !== 1'b0)
      $display("FAIL inflight_wait: got busy=%b valid=%b want 1 0", a_busy, a_rsp_valid);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0 || a_busy !== 1'b0)
      $display("FAIL inflight_reset: got valid=%b data=%h err=%b busy=%b want 0 0 0 0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    a_rsp_ready = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 4'b0000, 0, "load_prior");
  endtask

  // Instance B: requests held valid continuously, responses accepted immediately.
  task automatic test_back_to_back();
    localparam int N = 7;
    logic        wes   [N];
    logic [31:0] addrs [N];
    logic [31:0] datas [N];
    logic [3:0]  bes   [N];
    logic [32:0] exp;
    int k;
    int rsps;
    wes   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    addrs = '{32'h0, 32'hFC, 32'h0, 32'hFC, 32'h100, 32'h8, 32'h6};
    datas = '{32'hA5A5A5A5, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h77777777, 32'h0};
    bes   = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    k = 0;
    rsps = 0;
    b_rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && (k < N || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      total++;
      if (b_rsp_valid === b_req_ready)
        $display("FAIL b2b_alternate cyc%0d: got valid=%b ready=%b want opposite", cyc, b_rsp_valid, b_req_ready);
      else passed++;
      if (b_rsp_valid === 1'b1) begin
        rsps++;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_unexpected: got response err=%b data=%h want none", b_rsp_err, b_rsp_rdata);
        end else begin
          exp = exp_q.pop_front();
          if ({b_rsp_err, b_rsp_rdata} !== exp)
            $display("FAIL b2b_rsp%0d: got err=%b data=%h want err=%b data=%h",
                     rsps, b_rsp_err, b_rsp_rdata, exp[32], exp[31:0]);
          else passed++;
        end
      end
      if (b_req_ready === 1'b1 && k < N) begin
        exp_q.push_back(predict(1'b1, wes[k], addrs[k], datas[k], bes[k]));
        b_req_valid = 1'b1; b_req_we = wes[k]; b_req_addr = addrs[k];
        b_req_wdata = datas[k]; b_req_be = bes[k];
        k++;
      end else if (k >= N) begin
        b_req_valid = 1'b0;
      end
    end
    b_req_valid = 1'b0;
    total++;
    if (rsps != N) $display("FAIL b2b_count: got %0d responses want %0d", rsps, N);
    else passed++;
    @(negedge clk);
    total++;
    if (b_busy !== 1'b0 || b_rsp_valid !== 1'b0)
      $display("FAIL b2b_idle: got busy=%b valid=%b want 0 0", b_busy, b_rsp_valid);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0; b_rsp_ready = 1'b0;
    rst = 1'b0;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_reset_inflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
